// File: rtl/xpb_accum_seq.sv
// rtl/xpb_accum_seq.sv - chunked LUT accumulator: sums NUM_CHUNKS lookup values selected by hi_word chunks
// Optional build macro XPB_LUT_REG_EN: registers lut_value before the adder and adds a DRAIN state.
module xpb_accum_seq #(
  parameter int WORD_BITS  = 1024,
  parameter int CHUNK_BITS = 5,
  parameter int NUM_CHUNKS = 8,
  localparam int IDX_BITS  = $clog2(NUM_CHUNKS),
  localparam int ACC_BITS  = WORD_BITS + IDX_BITS,
  localparam int HI_BITS   = NUM_CHUNKS * CHUNK_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [HI_BITS-1:0]    hi_word,
  output logic [IDX_BITS-1:0]   lut_idx,
  output logic [CHUNK_BITS-1:0] lut_chunk,
  input  logic [WORD_BITS-1:0]  lut_value,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_BITS-1:0]   sum
);

`ifdef XPB_LUT_REG_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t                state_q, state_d;
  logic [HI_BITS-1:0]    shift_q, shift_d;
  logic [IDX_BITS-1:0]   cnt_q, cnt_d;
  logic [ACC_BITS-1:0]   acc_q, acc_d;
  logic                  last_chunk;

  assign last_chunk = (cnt_q == IDX_BITS'(NUM_CHUNKS - 1));

`ifdef XPB_LUT_REG_EN
  logic [WORD_BITS-1:0]  lut_q, lut_d;
  logic [ACC_BITS-1:0]   add_val;
  // Registered LUT result lags the presented chunk by one cycle; it is zero right after acceptance.
  assign add_val = {{IDX_BITS{1'b0}}, lut_q};
`else
  logic [ACC_BITS-1:0]   add_val;
  // LUT result is added in the same cycle its chunk is presented.
  assign add_val = {{IDX_BITS{1'b0}}, lut_value};
`endif

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: accept in IDLE, walk the chunks, hold result until it is taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (in_valid) state_d = ACCUM;
`ifdef XPB_LUT_REG_EN
      ACCUM: if (last_chunk) state_d = DRAIN;
      DRAIN: state_d = DONE;
`else
      ACCUM: if (last_chunk) state_d = DONE;
`endif
      DONE:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: handshakes and LUT addressing are pure functions of state.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    lut_idx   = '0;
    lut_chunk = '0;
    if (state_q == ACCUM) begin
      lut_idx   = cnt_q;
      lut_chunk = shift_q[CHUNK_BITS-1:0];
    end
  end

  // Datapath next values: load on acceptance, shift/count/accumulate while walking chunks.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
`ifdef XPB_LUT_REG_EN
    lut_d   = lut_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shift_d = hi_word;
          cnt_d   = '0;
          acc_d   = '0;
`ifdef XPB_LUT_REG_EN
          lut_d   = '0;
`endif
        end
      end
      ACCUM: begin
        shift_d = shift_q >> CHUNK_BITS;
        cnt_d   = cnt_q + IDX_BITS'(1);
        acc_d   = acc_q + add_val;
`ifdef XPB_LUT_REG_EN
        lut_d   = lut_value;
`endif
      end
`ifdef XPB_LUT_REG_EN
      DRAIN: begin
        acc_d = acc_q + add_val;
        lut_d = '0;
      end
`endif
      default: ;
    endcase
  end

  // Datapath registers; reset discards any operation in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
`ifdef XPB_LUT_REG_EN
      lut_q   <= '0;
`endif
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
`ifdef XPB_LUT_REG_EN
      lut_q   <= lut_d;
`endif
    end
  end

  assign sum = acc_q;

endmodule

// File: tb/tb_xpb_accum_seq.sv
// tb/tb_xpb_accum_seq.sv - self-checking bench for xpb_accum_seq (NUM_CHUNKS=4, WORD_BITS=1024)
module tb_xpb_accum_seq;
  localparam int WB  = 1024;
  localparam int CB  = 5;
  localparam int NC  = 4;
  localparam int IB  = 2;
  localparam int ACC = WB + IB;
  localparam int HB  = NC * CB;
`ifdef XPB_LUT_REG_EN
  localparam int LAT = NC + 1;
`else
  localparam int LAT = NC;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [HB-1:0]  hi_word;
  logic [IB-1:0]  lut_idx;
  logic [CB-1:0]  lut_chunk;
  logic [WB-1:0]  lut_value;
  logic           out_valid;
  logic           out_ready;
  logic [ACC-1:0] sum;
  logic           all_ones;

  logic [ACC-1:0] sb[$];
  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic [HB-1:0]  hi;
    logic           ones;
    logic [ACC-1:0] exp;
  } vec_t;

  xpb_accum_seq #(.WORD_BITS(WB), .CHUNK_BITS(CB), .NUM_CHUNKS(NC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .hi_word(hi_word), .lut_idx(lut_idx), .lut_chunk(lut_chunk),
    .lut_value(lut_value), .out_valid(out_valid), .out_ready(out_ready), .sum(sum)
  );

  always #5 clk = ~clk;

  // Bench LUT bank: value = chunk * (idx+1), or all-ones when selected.
  always_comb begin
    lut_value = '0;
    if (all_ones) lut_value = '1;
    else lut_value = WB'(lut_chunk) * (WB'(lut_idx) + WB'(1));
  end

  function automatic logic [ACC-1:0] model(input logic [HB-1:0] hi);
    logic [ACC-1:0] s = '0;
    for (int i = 0; i < NC; i++) s += ACC'(hi[i*CB +: CB]) * ACC'(i + 1);
    return s;
  endfunction

  task automatic chk(input string name, input logic [ACC-1:0] act, input logic [ACC-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got top=%h low=%h, want top=%h low=%h",
               name, act[ACC-1 -: 8], act[63:0], exp[ACC-1 -: 8], exp[63:0]);
    end
  endtask

  task automatic chkb(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Wait for out_valid after an acceptance edge, checking LUT addressing each cycle.
  task automatic wait_valid(input logic [HB-1:0] hi, input bit pulse);
    int n = 0;
    logic [HB-1:0] sh = hi;
    while (out_valid !== 1'b1 && n < 40) begin
      if (n < NC) begin
        chkb("lut_idx", int'(lut_idx), n);
        chkb("lut_chunk", int'(lut_chunk), int'(sh[CB-1:0]));
        sh = sh >> CB;
      end else begin
        chkb("lut_idx_drain", int'(lut_idx), 0);
        chkb("lut_chunk_drain", int'(lut_chunk), 0);
      end
      chkb("busy_in_ready", int'(in_ready), 0);
      in_valid = pulse && (n < 2);
      if (pulse) hi_word = 20'hFFFFF;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    chkb("latency", n, LAT);
  endtask

  task automatic pop_chk(input string name);
    if (sb.size() == 0) begin
      chkb({name, "_sb_empty"}, 0, 1);
    end else begin
      chk(name, sum, sb.pop_front());
    end
  endtask

  task automatic run_op(input logic [HB-1:0] hi, input logic ones, input int bp,
                        input logic [ACC-1:0] exp);
    all_ones = ones;
    hi_word  = hi;
    in_valid = 1'b1;
    chkb("idle_in_ready", int'(in_ready), 1);
    sb.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(hi, 1'b0);
    for (int k = 0; k < bp; k++) begin
      chk("bp_sum", sum, sb[0]);
      chkb("bp_in_ready", int'(in_ready), 0);
      @(posedge clk); #1;
      chkb("bp_out_valid", int'(out_valid), 1);
    end
    out_ready = 1'b1;
    pop_chk("sum");
    @(posedge clk); #1;
    out_ready = 1'b0;
    chkb("post_in_ready", int'(in_ready), 1);
    chkb("post_out_valid", int'(out_valid), 0);
  endtask

  initial begin
    vec_t vt[$];
    logic [HB-1:0] r;

    rst_n = 1'b0; in_valid = 1'b1; hi_word = 20'h20C41; out_ready = 1'b0; all_ones = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chkb("rst_in_ready", int'(in_ready), 1);
    chkb("rst_out_valid", int'(out_valid), 0);
    chk("rst_sum", sum, '0);
    chkb("rst_lut_idx", int'(lut_idx), 0);
    chkb("rst_lut_chunk", int'(lut_chunk), 0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chkb("rst_release_idle", int'(in_ready), 1);

    vt.push_back('{hi: 20'h20C41, ones: 1'b0, exp: ACC'(30)});
    vt.push_back('{hi: 20'h00000, ones: 1'b0, exp: ACC'(0)});
    vt.push_back('{hi: 20'hFFFFF, ones: 1'b0, exp: ACC'(310)});
    vt.push_back('{hi: 20'h20C41, ones: 1'b1, exp: ~ACC'(3)});
    for (int i = 0; i < 3; i++) begin
      r = HB'($urandom);
      vt.push_back('{hi: r, ones: 1'b0, exp: model(r)});
    end
    for (int i = 0; i < vt.size(); i++) begin
      run_op(vt[i].hi, vt[i].ones, 0, vt[i].exp);
      if (vt[i].ones) chkb("ones_top_bits", int'(sum[ACC-1 -: 2]), 3);
    end
    all_ones = 1'b0;

    // Backpressure: out_ready low for 5 cycles after out_valid.
    run_op(20'h20C41, 1'b0, 5, ACC'(30));

    // Reset during the second ACCUM cycle.
    hi_word = 20'hFFFFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chkb("midrst_in_ready", int'(in_ready), 1);
    chkb("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_sum", sum, '0);
    chkb("midrst_lut_idx", int'(lut_idx), 0);
    run_op(20'h20C41, 1'b0, 0, ACC'(30));

    // Back-to-back with an ignored in_valid pulse during ACCUM.
    out_ready = 1'b1;
    hi_word = 20'h20C41; in_valid = 1'b1;
    sb.push_back(ACC'(30));
    @(posedge clk); #1;
    wait_valid(20'h20C41, 1'b1);
    pop_chk("b2b_sum1");
    hi_word = 20'h0F0F0; in_valid = 1'b1;
    sb.push_back(model(20'h0F0F0));
    @(posedge clk); #1;
    chkb("b2b_idle_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    chkb("b2b_accepted", int'(in_ready), 0);
    in_valid = 1'b0;
    wait_valid(20'h0F0F0, 1'b0);
    pop_chk("b2b_sum2");
    @(posedge clk); #1;
    out_ready = 1'b0;
    chkb("b2b_end_idle", int'(in_ready), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/xpb_accum_seq.md
XPB_ACCUM_SEQ -- requirements
Module: xpb_accum_seq

Interface
REQ-001 SHALL have parameter WORD_BITS, default 1024: width of one lookup-table value.
REQ-002 SHALL have parameter CHUNK_BITS, default 5: width of one lookup-table select chunk.
REQ-003 SHALL have parameter NUM_CHUNKS, default 8 (legal range 2..64): number of chunks per operation.
REQ-004 SHALL have derived constants IDX_BITS = clog2(NUM_CHUNKS) and ACC_BITS = WORD_BITS + IDX_BITS.
REQ-005 SHALL have port clk, input, 1: single clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-007 SHALL have port in_valid, input, 1: hi_word is valid.
REQ-008 SHALL have port in_ready, output, 1: block accepts hi_word.
REQ-009 SHALL have port hi_word, input, NUM_CHUNKS*CHUNK_BITS: upper product bits; chunk i is bits [i*CHUNK_BITS +: CHUNK_BITS].
REQ-010 SHALL have port lut_idx, output, IDX_BITS: index of the chunk presented to the LUT bank.
REQ-011 SHALL have port lut_chunk, output, CHUNK_BITS: select value for the LUT addressed by lut_idx.
REQ-012 SHALL have port lut_value, input, WORD_BITS: combinational LUT result for lut_idx/lut_chunk, valid in the same cycle.
REQ-013 SHALL have port out_valid, output, 1: sum is valid.
REQ-014 SHALL have port out_ready, input, 1: consumer accepts sum.
REQ-015 SHALL have port sum, output, ACC_BITS: accumulated total of the LUT values, not modularly reduced.

Function
REQ-016 SHALL implement the states IDLE, ACCUM and DONE (plus DRAIN when XPB_LUT_REG_EN is defined).
REQ-017 SHALL drive in_ready = 1 only in IDLE and out_valid = 1 only in DONE.
REQ-018 On an edge where in_valid & in_ready, SHALL latch hi_word into a shift register, clear the accumulator, set the counter to 0 and enter ACCUM.
REQ-019 In ACCUM, SHALL drive lut_idx = counter and lut_chunk = shift register [CHUNK_BITS-1:0].
- Each ACCUM cycle: accumulator += zero-extended lut_value; shift register >>= CHUNK_BITS; counter += 1.
REQ-020 In ACCUM with counter == NUM_CHUNKS-1, SHALL perform the final accumulate and enter DONE.
- Latency: out_valid rises exactly NUM_CHUNKS cycles after the acceptance edge.
REQ-021 The accumulator SHALL be ACC_BITS wide and SHALL never overflow (NUM_CHUNKS values, each < 2^WORD_BITS).
REQ-022 In DONE, sum SHALL hold stable until out_valid & out_ready; on that edge the block SHALL enter IDLE.
REQ-023 Outside ACCUM, lut_idx and lut_chunk SHALL be 0.
- sum SHALL equal the accumulator in every state.
- lut_value SHALL be ignored outside ACCUM.
REQ-024 in_valid asserted outside IDLE SHALL be ignored; no input is queued.
REQ-025 Back-to-back: the IDLE cycle after a DONE handshake SHALL accept new input, giving a throughput of one operation per NUM_CHUNKS+2 cycles.

Reset
REQ-026 When rst_n == 0 at a rising clk edge, the block SHALL enter IDLE, from any state including mid-ACCUM, discarding the operation in progress.
REQ-027 After that reset edge, SHALL clear the accumulator, shift register, counter and any pipeline register to 0.
- Outputs after reset: in_ready = 1, out_valid = 0, sum = 0, lut_idx = 0, lut_chunk = 0.
REQ-028 While rst_n == 0, in_valid SHALL NOT be accepted.

Configuration
REQ-029 Macro XPB_LUT_REG_EN, when defined, SHALL register lut_value (WORD_BITS flop) before the adder.
- The add for chunk i occurs one cycle after chunk i is presented.
- After the last chunk, the block SHALL enter DRAIN for one cycle (final add) and then DONE.
- Latency becomes NUM_CHUNKS+1 cycles.
REQ-030 Macro XPB_LUT_REG_EN, when undefined, SHALL add lut_value directly in the same cycle, per REQ-019/REQ-020, with no DRAIN state.
- Final sum values are identical in both configurations.

Verification (NUM_CHUNKS=4, WORD_BITS=1024, bench LUT model: lut_value = lut_chunk * (lut_idx+1))
REQ-031 Nominal: hi_word = 20'h20C41 (chunks 1,2,3,4) -> sum = 30 (0x1E); out_valid rises 4 cycles after acceptance (5 cycles with XPB_LUT_REG_EN).
REQ-032 Extremes:
- hi_word = 0 -> sum = 0.
- hi_word = 20'hFFFFF -> sum = 310 (0x136).
- LUT model replaced by all-ones 1024-bit values -> sum = 4*(2^1024-1), bits [1025:1024] = 2'b11.
REQ-033 Backpressure: out_ready held low for 5 cycles after out_valid rises.
- sum stays stable and in_ready stays 0 throughout.
- Handshake on cycle 6 -> IDLE next cycle.
REQ-034 Reset mid-operation: rst_n = 0 during the 2nd ACCUM cycle.
- Next cycle: in_ready = 1, out_valid = 0, sum = 0.
- A following operation with hi_word = 20'h20C41 -> sum = 30.
REQ-035 Back-to-back and ignored input:
- Two operations with out_ready tied high -> second acceptance occurs in the first IDLE cycle after the first handshake.
- in_valid pulsed during ACCUM is not accepted.
- Sums are correct for both operations.
